// File: rtl/aes_ctr_round_sched.sv
// Batch sequencer for a bitsliced AES-CTR datapath. It splits a CTR job into
// batches of up to LANES counter blocks and steps each batch through load, NR rounds and output.
module aes_ctr_round_sched #(
   parameter int NR    = 10,
   parameter int LANES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 key_ready,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [95:0]          cfg_nonce,
   input  logic [31:0]          cfg_ctr,
   input  logic [15:0]          cfg_nblocks,
   output logic                 dp_load,
   output logic [95:0]          dp_nonce,
   output logic [32*LANES-1:0]  dp_ctr,
   output logic                 dp_round_en,
   output logic [3:0]           dp_round_idx,
   output logic                 dp_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2:0]           out_lanes,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {IDLE, LOAD, ROUND, OUTPUT} state_t;

   state_t       state_reg, state_next;
   logic [31:0]  ctr_reg, ctr_next;
   logic [15:0]  remaining_reg, remaining_next;
   logic [95:0]  nonce_reg, nonce_next;
   logic [3:0]   rnd_reg, rnd_next;
   logic         done_reg, done_next;

   logic [2:0]   batch_lanes;
   logic         batch_last;

   assign batch_last  = (remaining_reg <= 16'(LANES));
   assign batch_lanes = batch_last ? remaining_reg[2:0] : 3'(LANES);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         ctr_reg       <= '0;
         remaining_reg <= '0;
         nonce_reg     <= '0;
         rnd_reg       <= '0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         ctr_reg       <= ctr_next;
         remaining_reg <= remaining_next;
         nonce_reg     <= nonce_next;
         rnd_reg       <= rnd_next;
         done_reg      <= done_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      ctr_next       = ctr_reg;
      remaining_next = remaining_reg;
      nonce_next     = nonce_reg;
      rnd_next       = rnd_reg;
      done_next      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cfg_valid && key_ready) begin
               // An empty job completes without touching the datapath.
               if (cfg_nblocks == 16'd0) begin
                  done_next = 1'b1;
               end else begin
                  nonce_next     = cfg_nonce;
                  ctr_next       = cfg_ctr;
                  remaining_next = cfg_nblocks;
                  state_next     = LOAD;
               end
            end
         end
         LOAD: begin
            rnd_next   = 4'd1;
            state_next = ROUND;
         end
         ROUND: begin
            if (rnd_reg == 4'(NR)) state_next = OUTPUT;
            else                   rnd_next   = rnd_reg + 4'd1;
         end
         OUTPUT: begin
            if (out_ready) begin
               ctr_next       = ctr_reg + 32'(batch_lanes);
               remaining_next = remaining_reg - 16'(batch_lanes);
               if (batch_last) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  state_next = LOAD;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Only cfg_ready sees an input combinationally; everything else decodes registers.
   assign cfg_ready    = (state_reg == IDLE) && key_ready;
   assign busy         = (state_reg != IDLE);
   assign done         = done_reg;
   assign dp_load      = (state_reg == LOAD);
   assign dp_round_en  = (state_reg == ROUND);
   assign dp_round_idx = (state_reg == ROUND) ? rnd_reg : 4'd0;
   assign dp_last      = (state_reg == ROUND) && (rnd_reg == 4'(NR));
   assign dp_nonce     = nonce_reg;
   assign out_valid    = (state_reg == OUTPUT);
   assign out_lanes    = (state_reg == OUTPUT) ? batch_lanes : 3'd0;
   assign out_last     = (state_reg == OUTPUT) && batch_last;

   // Unused lanes still carry cur_ctr+i; the consumer masks them with out_lanes.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign dp_ctr[32*gi +: 32] = (state_reg == IDLE) ? 32'd0 : ctr_reg + 32'(gi);
      end
   endgenerate

endmodule

// File: doc/aes_ctr_round_sched.md
Name: aes_ctr_round_sched

Overview:
- Sequencer for the bitsliced (ct64) AES-CTR datapath.
- Accepts a CTR job (nonce, start counter, block count) and splits it into batches of up to LANES counter blocks.
- Per batch, drives the datapath through one load cycle and NR round cycles, then presents the batch to a downstream keystream consumer under valid/ready.
- Owns counter increment (32-bit wrap), lane-count bookkeeping and job completion signalling.

Parameters:
- NR, 10, number of AES rounds (10/12/14 legal; other values unsupported).
- LANES, 4, counter blocks processed in parallel per batch (1..4).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- key_ready  in  1  round keys valid in key schedule; gates job acceptance.
- cfg_valid  in  1  job request.
- cfg_ready  out  1  job accepted when cfg_valid&&cfg_ready.
- cfg_nonce  in  96  nonce, constant for whole job.
- cfg_ctr  in  32  first counter value.
- cfg_nblocks  in  16  blocks to generate; 0 legal.
- dp_load  out  1  load counter blocks into bitsliced state and apply round-key 0.
- dp_nonce  out  96  latched nonce.
- dp_ctr  out  32*LANES  lane i (bits 32i+31:32i) = cur_ctr+i mod 2^32.
- dp_round_en  out  1  datapath executes one round this cycle.
- dp_round_idx  out  4  round-key index: 0 during load, 1..NR during rounds.
- dp_last  out  1  final round; datapath skips MixColumns.
- out_valid  out  1  batch keystream ready.
- out_ready  in  1  downstream accepts.
- out_lanes  out  3  valid lanes in batch, 1..LANES.
- out_last  out  1  batch is final of job.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle job-complete pulse.

Behaviour:
- Reset (async assert, any state): state IDLE. All outputs 0 except cfg_ready, which follows key_ready. Internal ctr, remaining, nonce and round registers are all 0.
- FSM states: IDLE, LOAD, ROUND, OUTPUT.
- IDLE:
  - cfg_ready = key_ready.
  - On accept with nblocks==0: no datapath activity, done=1 next cycle, remain IDLE.
  - On accept with nblocks!=0: latch nonce, cur_ctr=cfg_ctr, remaining=nblocks; go to LOAD.
- LOAD (1 cycle):
  - dp_load=1, dp_round_idx=0, dp_round_en=0.
  - Next state ROUND with rnd=1.
- ROUND:
  - dp_round_en=1, dp_round_idx=rnd, dp_last=(rnd==NR).
  - If rnd==NR go to OUTPUT, else rnd+1.
  - Exactly NR round cycles per batch.
- OUTPUT:
  - out_valid=1, held stable with out_lanes and out_last until handshake.
  - out_lanes = min(remaining, LANES); out_last = (remaining <= LANES).
  - Datapath controls (dp_load, dp_round_en, dp_last) are 0.
  - On out_valid&&out_ready: cur_ctr += out_lanes (mod 2^32) and remaining -= out_lanes. If remaining reaches 0, go to IDLE and pulse done next cycle; else go to LOAD.
- Latency: accept at cycle T gives LOAD at T+1, rounds at T+2..T+NR+1, first out_valid at T+NR+2.
- Throughput: NR+2 cycles per batch with out_ready held high.
- Counter wrap:
  - Only the 32-bit counter wraps; the nonce is never modified.
  - Lanes beyond out_lanes still present cur_ctr+i; downstream ignores them.
- Back-to-back jobs: cfg_ready may rise in the cycle done pulses, so a new job can be accepted then.
- cfg_valid while busy is ignored (cfg_ready=0). cfg_* inputs are sampled only on accept.
- key_ready deasserting while busy has no effect on the running job.
- Registered outputs:
  - dp_* are registered outputs or decoded from the registered state only; no combinational path from any input.
  - The only exception is cfg_ready, which is combinational from key_ready in IDLE.

Test Plan:
- Reset then key_ready=1, job nonce=0x0A0B0C0D_0E0F1011_12131415, ctr=0x10, nblocks=4, LANES=4, NR=10, out_ready=1:
  - one LOAD cycle with dp_ctr lanes 0x10..0x13;
  - dp_round_idx 1..10, dp_last only on round 10;
  - out_valid at T+12 with out_lanes=4, out_last=1;
  - done one cycle later.
- nblocks=6: batch 1 has lanes 0x10..0x13, out_lanes=4, out_last=0; batch 2 has cur_ctr 0x14, out_lanes=2, out_last=1; total 24 cycles from accept to the last handshake cycle.
- ctr=0xFFFFFFFE, nblocks=4 → dp_ctr lanes FFFFFFFE, FFFFFFFF, 00000000, 00000001; dp_nonce unchanged.
- Backpressure: out_ready=0 for 5 cycles in OUTPUT → out_valid, out_lanes, out_last stable, no dp_load; counter advances only after handshake.
- Edge cases:
  - nblocks=0 → done pulse next cycle, busy stays 0, no dp_load.
  - key_ready=0 holds cfg_ready=0 and the job is not accepted.
  - cfg_valid during busy is ignored.
- Reset asserted mid-ROUND (rnd=5) → all outputs 0 immediately and state IDLE; a following job runs normally from round 1.
